// File: rtl/mm_result_drain_pkg.sv
// Shared definitions for the mm result drain: width defaults, state encodings
// and a width helper used to size the index and row/column fields.
package mm_result_drain_pkg;

    localparam int unsigned DEF_ACC_WIDTH = 32;
    localparam int unsigned DEF_EXP_WIDTH = 5;
    localparam int unsigned DEF_N         = 2;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    // ceil(log2(v)) but never less than 1, so single-entry fields still have a bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/mm_result_drain.sv
// mm_result_drain: snapshots all N*N accumulator/exponent pairs on each rising
// edge of done and streams them out row-major over a valid/ready port, so the
// array can start its next tile immediately.
//   clk, rst          clock; asynchronous active-low reset
//   done              mm completion level; rising edge = new tile
//   acc_in, exp_in    flattened PE results, PE l at [l*W +: W]
//   out_valid/ready   output handshake
//   out_data/out_exp  accumulator/exponent of current PE
//   out_row/out_col   PE coordinates, out_last flags the final PE
//   busy              snapshot held / streaming
//   overrun           sticky: a tile arrived while busy and was dropped
module mm_result_drain
    import mm_result_drain_pkg::*;
#(
    parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int unsigned EXP_WIDTH = DEF_EXP_WIDTH,
    parameter int unsigned N         = DEF_N
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         done,
    input  logic [N*N*ACC_WIDTH-1:0]     acc_in,
    input  logic [N*N*EXP_WIDTH-1:0]     exp_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_WIDTH-1:0]         out_data,
    output logic [EXP_WIDTH-1:0]         out_exp,
    output logic [clog2_min1(N)-1:0]     out_row,
    output logic [clog2_min1(N)-1:0]     out_col,
    output logic                         out_last,
    output logic                         busy,
    output logic                         overrun
);

    localparam int unsigned NN    = N * N;
    localparam int unsigned IDX_W = clog2_min1(NN);
    localparam int unsigned RC_W  = clog2_min1(N);

    logic [0:0]           state_q, state_d;
    logic [IDX_W-1:0]     index_q, index_d;
    logic                 done_q, done_d;
    logic                 armed_q, armed_d;
    logic                 overrun_q, overrun_d;
    logic [ACC_WIDTH-1:0] snap_acc_q [NN];
    logic [ACC_WIDTH-1:0] snap_acc_d [NN];
    logic [EXP_WIDTH-1:0] snap_exp_q [NN];
    logic [EXP_WIDTH-1:0] snap_exp_d [NN];

    logic                 out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] out_data_q,  out_data_d;
    logic [EXP_WIDTH-1:0] out_exp_q,   out_exp_d;
    logic [RC_W-1:0]      out_row_q,   out_row_d;
    logic [RC_W-1:0]      out_col_q,   out_col_d;
    logic                 out_last_q,  out_last_d;
    logic                 busy_q,      busy_d;

    logic done_rise;
    logic hs;
    logic final_hs;

    // State register, snapshot array and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            done_q      <= 1'b0;
            armed_q     <= 1'b0;
            overrun_q   <= 1'b0;
            for (int l = 0; l < NN; l++) begin
                snap_acc_q[l] <= '0;
                snap_exp_q[l] <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_exp_q   <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            done_q      <= done_d;
            armed_q     <= armed_d;
            overrun_q   <= overrun_d;
            snap_acc_q  <= snap_acc_d;
            snap_exp_q  <= snap_exp_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_exp_q   <= out_exp_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, capture and output-word computation.
    always_comb begin
        state_d    = state_q;
        index_d    = index_q;
        done_d     = done;
        armed_d    = 1'b1;
        overrun_d  = overrun_q;
        snap_acc_d = snap_acc_q;
        snap_exp_d = snap_exp_q;

        // armed_q masks the first cycle after reset so a done already high
        // at release is not mistaken for an edge.
        done_rise = done & ~done_q & armed_q;
        hs        = out_valid_q & out_ready;
        final_hs  = hs && (index_q == IDX_W'(NN - 1));

        case (state_q)
            S_IDLE: begin
                if (done_rise) begin
                    state_d = S_STREAM;
                    index_d = '0;
                    for (int l = 0; l < NN; l++) begin
                        snap_acc_d[l] = acc_in[l*ACC_WIDTH +: ACC_WIDTH];
                        snap_exp_d[l] = exp_in[l*EXP_WIDTH +: EXP_WIDTH];
                    end
                end
            end
            default: begin
                if (final_hs) begin
                    index_d = '0;
                    if (done_rise) begin
                        // Back-to-back tile: recapture and keep streaming.
                        for (int l = 0; l < NN; l++) begin
                            snap_acc_d[l] = acc_in[l*ACC_WIDTH +: ACC_WIDTH];
                            snap_exp_d[l] = exp_in[l*EXP_WIDTH +: EXP_WIDTH];
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    if (hs) begin
                        index_d = index_q + IDX_W'(1);
                    end
                    if (done_rise) begin
                        overrun_d = 1'b1;
                    end
                end
            end
        endcase

        // Outputs are registered from the next state, so they track state_q
        // exactly and are zero whenever idle.
        out_valid_d = (state_d == S_STREAM);
        busy_d      = (state_d == S_STREAM);
        out_data_d  = '0;
        out_exp_d   = '0;
        out_row_d   = '0;
        out_col_d   = '0;
        out_last_d  = 1'b0;
        if (state_d == S_STREAM) begin
            out_data_d = snap_acc_d[index_d];
            out_exp_d  = snap_exp_d[index_d];
            out_row_d  = RC_W'(index_d / IDX_W'(N));
            out_col_d  = RC_W'(index_d % IDX_W'(N));
            out_last_d = (index_d == IDX_W'(NN - 1));
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_exp   = out_exp_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule
